mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_if.sv | 33 +++
 rtl/mc_control.sv | 198 +++++++++++++++++++
 tb/tb_mc_control.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Control bundle between the multicycle controller and its datapath.
interface mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic       mem_timeout;

  modport master (
    input  op, funct, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
           mem_read, mem_write, reg_dst, mem_to_reg, reg_write, illegal, mem_timeout
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
           mem_read, mem_write, reg_dst, mem_to_reg, reg_write, illegal, mem_timeout
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM with memory-stall abort.
// Define MC_CONTROL_ADDI_EN to add the addi path (ADDIEX/ADDIWB).
//
// state  | meaning
// FETCH  | read instruction, PC+4
// DECODE | branch target into ALUOut, dispatch on op
// MEMADR | effective address for lw/sw
// MEMRD  | data read
// MEMWB  | load writeback
// MEMWR  | data write
// EXEC   | R-type ALU op from funct
// ALUWB  | R-type writeback
// BRANCH | beq compare, PC <- ALUOut if zero
// JUMP   | PC <- jump target
// ERR    | unsupported op/funct, illegal pulse
// ADDIEX | addi ALU op (optional)
// ADDIWB | addi writeback (optional)
module mc_control #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);
  localparam logic [7:0] LIMIT     = 8'(STALL_LIMIT);
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;
`ifdef MC_CONTROL_ADDI_EN
  localparam logic [5:0] OP_ADDI   = 6'b001000;
`endif

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ERR
`ifdef MC_CONTROL_ADDI_EN
    , ADDIEX, ADDIWB
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] stall_q;
  logic       in_mem, tmo;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c, illegal_c, tmo_c;

  assign in_mem = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign tmo    = in_mem && !bus.mem_ready && (stall_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      // a timed-out FETCH restarts itself, so the state compare alone misses it
      if (state_d != state_q || tmo)
        stall_q <= '0;
      else if (in_mem && !bus.mem_ready)
        stall_q <= stall_q + 8'd1;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.alu_op     = 3'b000;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    pc_write_c     = 1'b0;
    ir_write_c     = 1'b0;
    mem_write_c    = 1'b0;
    reg_write_c    = 1'b0;
    illegal_c      = 1'b0;
    tmo_c          = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 3'b010;
        pc_write_c    = bus.mem_ready;
        ir_write_c    = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_op    = 3'b010;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default:      state_d = ERR;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 3'b010;
        state_d       = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_c    = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        mem_write_c = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        state_d       = ALUWB;
        case (bus.funct)
          6'b100000: bus.alu_op = 3'b010;
          6'b100010: bus.alu_op = 3'b110;
          6'b100100: bus.alu_op = 3'b000;
          6'b100101: bus.alu_op = 3'b001;
          6'b101010: bus.alu_op = 3'b111;
          default:   state_d    = ERR;
        endcase
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        bus.reg_dst = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b110;
        bus.pc_src    = 2'b01;
        pc_write_c    = bus.zero;
        state_d       = FETCH;
      end
      JUMP: begin
        bus.pc_src = 2'b10;
        pc_write_c = 1'b1;
        state_d    = FETCH;
      end
`ifdef MC_CONTROL_ADDI_EN
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 3'b010;
        state_d       = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = FETCH;
      end
`endif
      ERR: begin
        illegal_c = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // a stall abort silences every strobe and select for that cycle
    if (tmo) begin
      bus.alu_op     = 3'b000;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.pc_src     = 2'b00;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      pc_write_c     = 1'b0;
      ir_write_c     = 1'b0;
      mem_write_c    = 1'b0;
      reg_write_c    = 1'b0;
      illegal_c      = 1'b0;
      tmo_c          = 1'b1;
      state_d        = FETCH;
    end
  end

  // write strobes and pulses are held off for as long as reset is asserted
  assign bus.pc_write    = pc_write_c  & rst_n;
  assign bus.ir_write    = ir_write_c  & rst_n;
  assign bus.mem_write   = mem_write_c & rst_n;
  assign bus.reg_write   = reg_write_c & rst_n;
  assign bus.illegal     = illegal_c   & rst_n;
  assign bus.mem_timeout = tmo_c       & rst_n;
endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-cycle trace model built from instruction descriptions.
module tb_mc_control;
  localparam int LIM = 4;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
`ifdef MC_CONTROL_ADDI_EN
  localparam int ADDI_LAT = 4;
  localparam int ILL_EXP  = 2;
`else
  localparam int ADDI_LAT = 3;
  localparam int ILL_EXP  = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mc_control_if bus();
  mc_control #(.STALL_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic       mem_timeout;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         id;
    ctl_t       exp;
  } cyc_t;

  cyc_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_ill = 0;
  int n_tmo = 0;
  int cur_id = 0;
  logic [5:0] cur_op = '0;
  logic [5:0] cur_funct = '0;
  logic cur_zero = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // expected control word for each phase of an instruction
  function automatic ctl_t ph_fetch(input logic rdy);
    ctl_t c = '0;
    c.alu_op = 3'b010; c.alu_src_b = 2'b01; c.mem_read = 1'b1;
    c.pc_write = rdy; c.ir_write = rdy;
    return c;
  endfunction
  function automatic ctl_t ph_decode();
    ctl_t c = '0;
    c.alu_op = 3'b010; c.alu_src_b = 2'b11;
    return c;
  endfunction
  function automatic ctl_t ph_addr();
    ctl_t c = '0;
    c.alu_op = 3'b010; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t ph_rd();
    ctl_t c = '0;
    c.mem_read = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t ph_wr();
    ctl_t c = '0;
    c.mem_write = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t ph_wb(input logic from_mem, input logic rd_field);
    ctl_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = from_mem; c.reg_dst = rd_field;
    return c;
  endfunction
  function automatic int alu_for(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction
  function automatic ctl_t ph_exec(input logic [5:0] f);
    ctl_t c = '0;
    c.alu_src_a = 1'b1;
    if (alu_for(f) >= 0) c.alu_op = 3'(alu_for(f));
    return c;
  endfunction
  function automatic ctl_t ph_branch(input logic z);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b110; c.pc_src = 2'b01; c.pc_write = z;
    return c;
  endfunction
  function automatic ctl_t ph_jump();
    ctl_t c = '0;
    c.pc_src = 2'b10; c.pc_write = 1'b1;
    return c;
  endfunction
  function automatic ctl_t ph_err();
    ctl_t c = '0;
    c.illegal = 1'b1;
    return c;
  endfunction
  function automatic ctl_t ph_tmo();
    ctl_t c = '0;
    c.mem_timeout = 1'b1;
    return c;
  endfunction

  task automatic push(input logic rst, input logic rdy, input ctl_t e);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.op = cur_op; c.funct = cur_funct;
    c.zero = cur_zero; c.id = cur_id; c.exp = e;
    q.push_back(c);
  endtask

  // a memory wait of up to LIM cycles completes; one more aborts the transfer
  task automatic mem_phase(input ctl_t busy, input ctl_t done, input int waits, output bit ok);
    for (int i = 0; i < waits && i < LIM; i++) push(1'b1, 1'b0, busy);
    if (waits > LIM) begin
      push(1'b1, 1'b0, ph_tmo());
      ok = 1'b0;
    end else begin
      push(1'b1, 1'b1, done);
      ok = 1'b1;
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                     input int fw, input int mw, input int keep, input int lat);
    int start = q.size();
    int w = fw;
    bit ok;
    cur_id++; cur_op = op; cur_funct = funct; cur_zero = zero;
    do begin
      mem_phase(ph_fetch(1'b0), ph_fetch(1'b1), w, ok);
      w -= LIM + 1;
    end while (!ok);
    push(1'b1, 1'b0, ph_decode());
    case (op)
      LW: begin
        push(1'b1, 1'b0, ph_addr());
        mem_phase(ph_rd(), ph_rd(), mw, ok);
        if (ok) push(1'b1, 1'b0, ph_wb(1'b1, 1'b0));
      end
      SW: begin
        push(1'b1, 1'b0, ph_addr());
        mem_phase(ph_wr(), ph_wr(), mw, ok);
      end
      RT: begin
        push(1'b1, 1'b0, ph_exec(funct));
        if (alu_for(funct) >= 0) push(1'b1, 1'b0, ph_wb(1'b0, 1'b1));
        else push(1'b1, 1'b0, ph_err());
      end
      BEQ: push(1'b1, 1'b0, ph_branch(zero));
      JMP: push(1'b1, 1'b0, ph_jump());
`ifdef MC_CONTROL_ADDI_EN
      ADDI: begin
        push(1'b1, 1'b0, ph_addr());
        push(1'b1, 1'b0, ph_wb(1'b0, 1'b0));
      end
`endif
      default: push(1'b1, 1'b0, ph_err());
    endcase
    check($sformatf("latency instr%0d", cur_id), q.size() - start, lat);
    if (keep >= 0)
      while (q.size() > start + keep) void'(q.pop_back());
  endtask

  // reset with mem_ready high: FETCH selects visible, every write strobe low
  task automatic reset_cycle();
    push(1'b0, 1'b1, ph_fetch(1'b0));
  endtask

  initial begin
    cyc_t c;
    ctl_t act;
    int cyc = 0;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    reset_cycle();
    reset_cycle();
    run(RT,  6'b101010, 1'b0, 0, 0, -1, 4);
    run(LW,  6'b000000, 1'b0, 0, 0, -1, 5);
    run(LW,  6'b000000, 1'b0, 0, 3, -1, 8);
    run(SW,  6'b000000, 1'b0, 0, 0, -1, 4);
    run(BEQ, 6'b000000, 1'b1, 0, 0, -1, 3);
    run(BEQ, 6'b000000, 1'b0, 0, 0, -1, 3);
    run(JMP, 6'b000000, 1'b0, 0, 0, -1, 3);
    run(ADDI, 6'b000000, 1'b0, 0, 0, -1, ADDI_LAT);
    run(6'b111111, 6'b000000, 1'b0, 0, 0, -1, 3);
    run(RT,  6'b000111, 1'b0, 0, 0, -1, 4);
    run(RT,  6'b100000, 1'b0, 2, 0, -1, 6);
    run(RT,  6'b100010, 1'b0, 0, 0, -1, 4);
    run(RT,  6'b100100, 1'b0, 0, 0, -1, 4);
    run(RT,  6'b100101, 1'b0, 0, 0, -1, 4);
    run(LW,  6'b000000, 1'b0, 0, 4, -1, 9);
    run(BEQ, 6'b000000, 1'b1, 4, 0, -1, 7);
    run(SW,  6'b000000, 1'b0, 0, 5, -1, 8);
    run(JMP, 6'b000000, 1'b0, 5, 0, -1, 8);
    run(JMP, 6'b000000, 1'b0, 9, 0, -1, 12);
    run(LW,  6'b000000, 1'b0, 0, 2, 4, 7);
    reset_cycle();
    run(RT,  6'b100101, 1'b0, 0, 0, -1, 4);

    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst_n = c.rst;
      bus.mem_ready = c.rdy;
      bus.op = c.op;
      bus.funct = c.funct;
      bus.zero = c.zero;
      #1;
      act = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.pc_write,
             bus.ir_write, bus.iord, bus.mem_read, bus.mem_write, bus.reg_dst,
             bus.mem_to_reg, bus.reg_write, bus.illegal, bus.mem_timeout};
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL ctl instr%0d cyc%0d: got %05h, expected %05h", c.id, cyc, act, c.exp);
      end
      if (bus.illegal === 1'b1) n_ill++;
      if (bus.mem_timeout === 1'b1) n_tmo++;
      cyc++;
    end

    check("illegal pulses", n_ill, ILL_EXP);
    check("timeout pulses", n_tmo, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
